// File: rtl/sd_fdd_arbiter.sv
// sd_fdd_arbiter
// Shares the single HPS SD block channel between two floppy-controller clients.
// One sector request is granted at a time. The LBA and the direction are latched
// at grant. Buffer traffic is steered to the owning client while the transfer is
// in flight. A transfer that stalls for TIMEOUT cycles is aborted.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   c_lba[63:0]         client LBAs ([31:0] client 0, [63:32] client 1)
//   c_rd, c_wr [1:0]    per-client read / write request levels
//   c_ack [1:0]         per-client acknowledge (owner only)
//   c_buff_din[15:0]    per-client write data ([7:0] client 0, [15:8] client 1)
//   c_buff_wr [1:0]     per-client buffer write strobe (owner only)
//   c_buff_addr, c_buff_dout  HPS buffer address / data, passed through
//   sd_lba, sd_rd, sd_wr, sd_dev  request to HPS and owning client index
//   sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr  HPS handshake and buffer side
//   sd_buff_din         owner's write data returned to HPS
//   busy                high whenever the arbiter is not idle
//   timeout_err         sticky abort flag, cleared at the next grant
module sd_fdd_arbiter #(
    parameter int unsigned     TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] c_lba,
    input  logic [1:0]  c_rd,
    input  logic [1:0]  c_wr,
    output logic [1:0]  c_ack,
    input  logic [15:0] c_buff_din,
    output logic [1:0]  c_buff_wr,
    output logic [8:0]  c_buff_addr,
    output logic [7:0]  c_buff_dout,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_dev,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StHold} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            dev_q, dev_d;      // also the current owner
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [1:0] pend;
    logic       grant_idx;
    logic       active;
    logic       timed_out;

    assign pend      = c_rd | c_wr;
    // On a tie the client that was not served last wins.
    assign grant_idx = (pend == 2'b11) ? ~last_q : pend[1];
    assign active    = (state_q == StReq) || (state_q == StXfer);
    assign timed_out = active && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dev_d   = dev_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // Saturating counter: it stops at the abort value and never wraps.
        if (active && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (pend != 2'b00) begin
                    dev_d   = grant_idx;
                    lba_d   = grant_idx ? c_lba[63:32] : c_lba[31:0];
                    rd_d    = c_rd[grant_idx];
                    wr_d    = ~c_rd[grant_idx];   // read wins when both are high
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (timed_out) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    last_d  = dev_q;
                    state_d = StIdle;
                end else if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (timed_out) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    last_d  = dev_q;
                    state_d = StIdle;
                end else if (!sd_ack) begin
                    last_d  = dev_q;
                    state_d = StHold;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            dev_q   <= 1'b0;
            lba_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            dev_q   <= dev_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational steering: zero latency from the HPS handshake to the owner.
    always_comb begin
        c_ack       = 2'b00;
        c_buff_wr   = 2'b00;
        sd_buff_din = 8'd0;
        if (active) begin
            c_ack[dev_q]     = sd_ack;
            c_buff_wr[dev_q] = sd_buff_wr;
            sd_buff_din      = dev_q ? c_buff_din[15:8] : c_buff_din[7:0];
        end
    end

    assign c_buff_addr = sd_buff_addr;
    assign c_buff_dout = sd_buff_dout;
    assign sd_lba      = lba_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_dev      = dev_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = err_q;

endmodule
